// File: rtl/td4_core_if.sv
// Program-ROM / IO bundle of the TD4 core. The core side drives the ROM
// address, the output latch and the register taps; the system side supplies
// the fetched instruction, the input port and the execute enable.
interface td4_core_if;
  logic       clk_en;
  logic [3:0] address;
  logic [7:0] instr;
  logic [3:0] in_port;
  logic [3:0] out_port;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic       carry;

  modport master (
    input  clk_en, instr, in_port,
    output address, out_port, reg_a, reg_b, carry
  );

  modport slave (
    output clk_en, instr, in_port,
    input  address, out_port, reg_a, reg_b, carry
  );
endinterface

// File: rtl/td4_core.sv
// TD4 4-bit CPU core. One instruction retires per enabled clock; the ROM is
// read combinationally from the current PC in the same cycle. Every executed
// instruction goes through a single 5-bit adder (src + Im) whose carry-out
// becomes the new C, so immediate/jump/NOP forms use src = 0 and clear C.
module td4_core #(
  parameter logic [3:0] RESET_PC  = 4'h0,
  parameter logic [3:0] OUT_RESET = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  td4_core_if.master  bus
);

  typedef enum logic [1:0] {
    DST_NONE,
    DST_A,
    DST_B,
    DST_OUT
  } dst_e;

  logic [3:0] pc_q, a_q, b_q, out_q;
  logic       c_q;

  logic [3:0] opcode, im;
  logic [3:0] src;
  logic [4:0] sum;
  dst_e       dst;
  logic [3:0] pc_nxt, a_nxt, b_nxt, out_nxt;
  logic       c_nxt;

  assign opcode = bus.instr[7:4];
  assign im     = bus.instr[3:0];

  // Decode: pick the adder source and destination, then form next state.
  always_comb begin
    src     = 4'h0;
    dst     = DST_NONE;
    pc_nxt  = pc_q + 4'h1;
    case (opcode)
      4'b0000: begin src = a_q;         dst = DST_A;   end
      4'b0101: begin src = b_q;         dst = DST_B;   end
      4'b0011: begin src = 4'h0;        dst = DST_A;   end
      4'b0111: begin src = 4'h0;        dst = DST_B;   end
      4'b0001: begin src = b_q;         dst = DST_A;   end
      4'b0100: begin src = a_q;         dst = DST_B;   end
      4'b0010: begin src = bus.in_port; dst = DST_A;   end
      4'b0110: begin src = bus.in_port; dst = DST_B;   end
      4'b1001: begin src = b_q;         dst = DST_OUT; end
      4'b1011: begin src = 4'h0;        dst = DST_OUT; end
      4'b1111: pc_nxt = im;
      // Branch tests the carry as it stood before this edge.
      4'b1110: if (!c_q) pc_nxt = im;
      default: ;
    endcase

    sum     = {1'b0, src} + {1'b0, im};
    c_nxt   = sum[4];
    a_nxt   = (dst == DST_A)   ? sum[3:0] : a_q;
    b_nxt   = (dst == DST_B)   ? sum[3:0] : b_q;
    out_nxt = (dst == DST_OUT) ? sum[3:0] : out_q;
  end

  // Architectural state: reset dominates, otherwise retire only when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      a_q   <= 4'h0;
      b_q   <= 4'h0;
      c_q   <= 1'b0;
      out_q <= OUT_RESET;
    end else if (bus.clk_en) begin
      pc_q  <= pc_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      c_q   <= c_nxt;
      out_q <= out_nxt;
    end
  end

  assign bus.address  = pc_q;
  assign bus.out_port = out_q;
  assign bus.reg_a    = a_q;
  assign bus.reg_b    = b_q;
  assign bus.carry    = c_q;

endmodule

// File: tb/tb_td4_core.sv
// Bench for td4_core: directed program fragments followed by random programs,
// all checked against an instruction-level reference model.
module tb_td4_core;

  logic clk;
  logic reset;
  td4_core_if bus ();

  td4_core #(.RESET_PC(4'h0), .OUT_RESET(4'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference machine state.
  int m_pc, m_a, m_b, m_c, m_out;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction of the TD4 ISA at the level of the programmer's manual.
  task automatic model_exec(input int ins, input int inp, input bit en, input bit rst);
    int op, im, s, sum, res;
    int which; // 0 none, 1 A, 2 B, 3 OUT
    if (rst) begin
      m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0;
      return;
    end
    if (!en) return;
    op = ins / 16;
    im = ins % 16;
    s = 0;
    which = 0;
    case (op)
      0:  begin s = m_a; which = 1; end
      1:  begin s = m_b; which = 1; end
      2:  begin s = inp; which = 1; end
      3:  begin s = 0;   which = 1; end
      4:  begin s = m_a; which = 2; end
      5:  begin s = m_b; which = 2; end
      6:  begin s = inp; which = 2; end
      7:  begin s = 0;   which = 2; end
      9:  begin s = m_b; which = 3; end
      11: begin s = 0;   which = 3; end
      default: ;
    endcase
    sum = s + im;
    res = sum % 16;
    if (op == 15)                   m_pc = im;
    else if (op == 14 && m_c == 0)  m_pc = im;
    else                            m_pc = (m_pc + 1) % 16;
    m_c = (sum > 15) ? 1 : 0;
    if (which == 1) m_a = res;
    if (which == 2) m_b = res;
    if (which == 3) m_out = res;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},  {4'h0, bus.address},  8'(m_pc));
    chk({tag, ".a"},   {4'h0, bus.reg_a},    8'(m_a));
    chk({tag, ".b"},   {4'h0, bus.reg_b},    8'(m_b));
    chk({tag, ".c"},   {7'h0, bus.carry},    8'(m_c));
    chk({tag, ".out"}, {4'h0, bus.out_port}, 8'(m_out));
  endtask

  task automatic step(input logic [7:0] ins, input logic [3:0] inp,
                      input logic en, input logic rst, input string tag);
    @(negedge clk);
    bus.instr   = ins;
    bus.in_port = inp;
    bus.clk_en  = en;
    reset       = rst;
    @(posedge clk);
    model_exec(int'(ins), int'(inp), en, rst);
    #1;
    check_all(tag);
  endtask

  logic [7:0] rom [16];

  initial begin
    reset = 1'b1;
    bus.instr = 8'h80;
    bus.in_port = 4'h0;
    bus.clk_en = 1'b0;
    m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0;

    // Reset values.
    step(8'h80, 4'h0, 1'b0, 1'b1, "reset");
    chk("reset_addr", {4'h0, bus.address}, 8'h00);

    // MOV A then ADD overflow, JNC not taken then taken.
    step(8'h35, 4'h0, 1'b1, 1'b0, "mov_a");
    chk("mov_a_val", {4'h0, bus.reg_a}, 8'h05);
    step(8'h0C, 4'h0, 1'b1, 1'b0, "add_ovf");
    chk("add_ovf_a", {4'h0, bus.reg_a}, 8'h01);
    chk("add_ovf_c", {7'h0, bus.carry}, 8'h01);
    step(8'hE0, 4'h0, 1'b1, 1'b0, "jnc_nt");
    chk("jnc_nt_addr", {4'h0, bus.address}, 8'h03);
    chk("jnc_nt_c", {7'h0, bus.carry}, 8'h00);
    step(8'hE0, 4'h0, 1'b1, 1'b0, "jnc_t");
    chk("jnc_t_addr", {4'h0, bus.address}, 8'h00);

    // JMP from PC=2, then PC wrap from F.
    step(8'h80, 4'h0, 1'b1, 1'b0, "nop0");
    step(8'hA0, 4'h0, 1'b1, 1'b0, "nop1");
    step(8'hF9, 4'h0, 1'b1, 1'b0, "jmp9");
    chk("jmp9_addr", {4'h0, bus.address}, 8'h09);
    step(8'hFF, 4'h0, 1'b1, 1'b0, "jmpf");
    step(8'h7A, 4'h0, 1'b1, 1'b0, "wrap");
    chk("wrap_addr", {4'h0, bus.address}, 8'h00);
    chk("wrap_b", {4'h0, bus.reg_b}, 8'h0A);

    // IN, MOV B,A, OUT B, OUT Im.
    step(8'h20, 4'hA, 1'b1, 1'b0, "in_a");
    chk("in_a_val", {4'h0, bus.reg_a}, 8'h0A);
    step(8'h40, 4'h3, 1'b1, 1'b0, "mov_ba");
    chk("mov_ba_val", {4'h0, bus.reg_b}, 8'h0A);
    step(8'h91, 4'h3, 1'b1, 1'b0, "out_b");
    chk("out_b_val", {4'h0, bus.out_port}, 8'h0B);
    step(8'hB7, 4'h3, 1'b1, 1'b0, "out_im");
    chk("out_im_val", {4'h0, bus.out_port}, 8'h07);

    // Hold with execute disabled.
    for (int i = 0; i < 5; i++) step(8'h01, 4'h5, 1'b0, 1'b0, "hold");

    // Timer program, reset mid-loop while enabled.
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    rom[0] = 8'hB7; rom[1] = 8'h01; rom[2] = 8'hE1;
    step(8'h80, 4'h0, 1'b1, 1'b1, "prog_rst");
    for (int i = 0; i < 20; i++) step(rom[m_pc], 4'h0, 1'b1, 1'b0, "timer");
    step(rom[m_pc], 4'h0, 1'b1, 1'b1, "mid_rst");
    chk("mid_rst_addr", {4'h0, bus.address}, 8'h00);
    chk("mid_rst_out", {4'h0, bus.out_port}, 8'h00);
    for (int i = 0; i < 3; i++) step(rom[m_pc], 4'h0, 1'b1, 1'b0, "restart");
    chk("restart_out", {4'h0, bus.out_port}, 8'h07);

    // Random programs with random enable, input and occasional reset.
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 60; i++)
        step(rom[m_pc], 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
